// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg_scan_pkg                                                |
// | Brief  : Shared types and constants for the 7-segment scan control.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package seg_scan_pkg;

  // Width of one BCD digit code.
  localparam int NIB_W = 4;

  // Scan phase within a digit slot.
  typedef enum logic [0:0] {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg_scan_timer                                              |
// | Brief  : Free-running digit-slot counter with guard-end and          |
// |          slot-end strobes.                                           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seg_scan_timer #(
  parameter int SLOT_CYC  = 1000,
  parameter int GUARD_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic guard_end,
  output logic slot_end
);

  localparam int                CNT_W      = $clog2(SLOT_CYC);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Slot counter: 0 .. SLOT_CYC-1, wrapping at the end of every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == SLOT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Strobes mark the last cycle of the guard phase and of the whole slot.
  assign guard_end = (cnt == GUARD_LAST);
  assign slot_end  = (cnt == SLOT_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg_scan_ctrl                                               |
// | Brief  : Multiplexed BCD display scanner with double-buffered,       |
// |          tear-free display word, anti-ghost guard time, lamp test    |
// |          and blanking. All outputs registered.                       |
// | Macro  : SEG_SCAN_LZB_EN - enables leading-zero blanking.            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 1000,
  parameter int GUARD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [NIB_W*DIGITS-1:0] wr_data,
  input  logic                  test,
  input  logic                  blank,
  output logic [NIB_W-1:0]      seg_data,
  output logic                  seg_le,
  output logic                  seg_lt,
  output logic                  seg_bl,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  localparam int                IDX_W    = $clog2(DIGITS);
  localparam int                WORD_W   = NIB_W * DIGITS;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  scan_state_t       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              wrap;
  logic              guard_end, slot_end;
  logic [WORD_W-1:0] active, pending;
  logic [NIB_W-1:0]  cur_nib;
  logic              lzb;

  seg_scan_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .GUARD_CYC (GUARD_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .guard_end (guard_end),
    .slot_end  (slot_end)
  );

  // State and digit-index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GUARD;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; wrap flags the last SHOW cycle of the final digit.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wrap      = 1'b0;
    case (state)
      GUARD: begin
        if (guard_end) state_nxt = SHOW;
      end
      SHOW: begin
        if (slot_end) begin
          state_nxt = GUARD;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = GUARD;
    endcase
  end

  // Double buffer: wr_ready doubles as the inverted pend_full flag, so the
  // wrap transfer and a new capture can never collide in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= '0;
      pending  <= '0;
      wr_ready <= 1'b1;
    end else if (wrap && !wr_ready) begin
      active   <= pending;
      wr_ready <= 1'b1;
    end else if (wr_valid && wr_ready) begin
      pending  <= wr_data;
      wr_ready <= 1'b0;
    end
  end

  assign cur_nib = active[idx*NIB_W +: NIB_W];

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero blank: this nibble and every higher one are zero, never digit 0.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    lzb         = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (active[i*NIB_W +: NIB_W] == '0);
      if (i == int'(idx)) lzb = higher_zero && (i != 0);
    end
  end
`else
  assign lzb = 1'b0;
`endif

  // Output registers: driver controls follow the current scan phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_en     <= '0;
      seg_data   <= '0;
      seg_le     <= 1'b0;
      seg_lt     <= 1'b0;
      seg_bl     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      seg_data   <= cur_nib;
      seg_lt     <= test;
      frame_done <= wrap;
      if (state == SHOW) begin
        dig_en <= {{(DIGITS-1){1'b0}}, 1'b1} << idx;
        seg_le <= 1'b1;
        seg_bl <= blank | lzb;
      end else begin
        dig_en <= '0;
        seg_le <= 1'b0;
        seg_bl <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_seg_scan_ctrl                                            |
// | Brief  : Directed self-checking bench for seg_scan_ctrl              |
// |          (DIGITS=4, SLOT_CYC=8, GUARD_CYC=2). Honours SEG_SCAN_LZB_EN.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SLOT_CYC  = 8;
  localparam int GUARD_CYC = 2;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        test;
  logic        blank;
  logic [3:0]  seg_data;
  logic        seg_le;
  logic        seg_lt;
  logic        seg_bl;
  logic [3:0]  dig_en;
  logic        frame_done;
  logic [11:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SLOT_CYC  (SLOT_CYC),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .test       (test),
    .blank      (blank),
    .seg_data   (seg_data),
    .seg_le     (seg_le),
    .seg_lt     (seg_lt),
    .seg_bl     (seg_bl),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {frame_done, seg_lt, seg_le, seg_bl, seg_data, dig_en};

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] expv(input logic fd, input logic lt, input logic le,
                                       input logic bl, input logic [3:0] d, input logic [3:0] g);
    return {fd, lt, le, bl, d, g};
  endfunction

  // Check one whole 32-cycle frame, starting on the cycle after a frame_done.
  task automatic check_frame(input logic [15:0] word, input logic [3:0] mask,
                             input logic blk, input string tag);
    for (int p = 0; p < 32; p++) begin
      int          s;
      int          q;
      logic [3:0]  nib;
      logic [11:0] e;
      s   = p / 8;
      q   = p % 8;
      nib = word[s*4 +: 4];
      @(negedge clk);
      if (q < GUARD_CYC) e = expv(p == 31, 1'b0, 1'b0, 1'b1, nib, 4'b0000);
      else               e = expv(p == 31, 1'b0, 1'b1, blk | mask[s], nib, 4'b0001 << s);
      chk($sformatf("%s p%0d", tag, p), {20'b0, obs}, {20'b0, e});
    end
  endtask

  task automatic wait_frame_done(input string tag);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_done && i < 100);
    chk(tag, frame_done, 1);
  endtask

  // Offer a word from a negedge; returns on the negedge after capture.
  task automatic write_word(input logic [15:0] d, input string tag);
    int   i;
    logic acc;
    wr_valid = 1'b1;
    wr_data  = d;
    i = 0;
    while (!wr_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    acc = wr_ready;
    @(negedge clk);
    wr_valid = 1'b0;
    chk(tag, acc, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    test     = 1'b0;
    blank    = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst outs", obs, expv(0, 0, 0, 1, 4'h0, 4'b0000));
    chk("rst wr_ready", wr_ready, 1);

    // First frame after release: guard for digit 0 on the very next edge
    rst_n = 1'b1;
    check_frame(16'h0000, LZB ? 4'b1110 : 4'b0000, 1'b0, "post-rst");

    // Basic word, visible from the frame after the next wrap
    write_word(16'h1234, "wr 1234");
    wait_frame_done("fd 1234");
    check_frame(16'h1234, 4'b0000, 1'b0, "f1234");

    // Back-to-back writes mid-frame: second waits for the wrap
    repeat (10) @(negedge clk);
    write_word(16'h1111, "wr 1111");
    chk("busy after 1111", wr_ready, 0);
    fork
      write_word(16'h2222, "wr 2222");
    join_none
    wait_frame_done("fd 1111");
    check_frame(16'h1111, 4'b0000, 1'b0, "f1111");
    check_frame(16'h2222, 4'b0000, 1'b0, "f2222");

    // Leading-zero blanking pattern
    write_word(16'h0070, "wr 0070");
    wait_frame_done("fd 0070");
    check_frame(16'h0070, LZB ? 4'b1100 : 4'b0000, 1'b0, "f0070");

    // blank / test mid-SHOW of digit 0, one-cycle latency
    repeat (5) @(negedge clk);
    chk("pre blank bl", seg_bl, 0);
    chk("pre test lt", seg_lt, 0);
    blank = 1'b1;
    @(negedge clk);
    chk("blank bl", seg_bl, 1);
    chk("blank dig", dig_en, 4'b0001);
    blank = 1'b0;
    test  = 1'b1;
    @(negedge clk);
    chk("test lt", seg_lt, 1);
    chk("test bl", seg_bl, 0);
    chk("test dig", dig_en, 4'b0001);
    test = 1'b0;
    @(negedge clk);
    chk("test off lt", seg_lt, 0);
    chk("test off dig", dig_en, 4'b0001);

    // A whole frame with blank held high
    wait_frame_done("fd blank");
    blank = 1'b1;
    check_frame(16'h0070, LZB ? 4'b1100 : 4'b0000, 1'b1, "fblank");
    blank = 1'b0;

    // Reset during SHOW of digit 2 with a word pending
    write_word(16'h5555, "wr 5555");
    repeat (19) @(negedge clk);
    chk("pre-rst dig", dig_en, 4'b0100);
    chk("pre-rst busy", wr_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst outs", obs, expv(0, 0, 0, 1, 4'h0, 4'b0000));
    chk("async rst wr_ready", wr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, LZB ? 4'b1110 : 4'b0000, 1'b0, "restart");
    check_frame(16'h0000, LZB ? 4'b1110 : 4'b0000, 1'b0, "restart2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
